nios2_wrin_arb: RTL and testbench
=================================

NIOS2_WRIN_ARB -- requirements
Module: nios2_wrin_arb

Interface
REQ-001 SHALL provide port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide ports m0_read, m1_read  in  1  requester read strobe.
REQ-004 SHALL provide ports m0_address, m1_address  in  2  requester word address.
REQ-005 SHALL provide ports m0_waitrequest, m1_waitrequest  out  1  requester stall.
REQ-006 SHALL provide ports m0_readdata, m1_readdata  out  32  returned data.
REQ-007 SHALL provide ports m0_readdatavalid, m1_readdatavalid  out  1  one-cycle data-valid pulse.
REQ-008 SHALL provide port: s_address  out  2  address to the shared input-PIO slave.
REQ-009 SHALL provide port: s_readdata  in  32  PIO read data, registered by the PIO one clock after s_address.

Function
REQ-010 SHALL share the single input-PIO read port between requesters m0 and m1, one transaction at a time.
REQ-011 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; only IDLE accepts a request.
REQ-012 IDLE: if any mN_read, SHALL grant one requester, drive its mN_waitrequest low that cycle (accept), latch address and owner, go to ADDR; else stay IDLE.
REQ-013 ADDR: SHALL present latched address on s_address; next state DATA.
REQ-014 DATA: SHALL register s_readdata into a data register; next state IDLE.
REQ-015 SHALL pulse owner's mN_readdatavalid for exactly one cycle, with mN_readdata valid, 3 cycles after the accept cycle.
REQ-016 Non-owner readdatavalid SHALL be 0; mN_readdata SHALL hold last captured value for both requesters.
REQ-017 mN_waitrequest SHALL equal mN_read AND NOT accepted-this-cycle; ADDR and DATA never accept.
REQ-018 Back-to-back: the readdatavalid cycle SHALL coincide with IDLE, so a new accept is possible then; throughput one read per 3 cycles.
REQ-019 s_address SHALL equal the latched-address register at all times (held between transactions).
REQ-020 Deasserting mN_read while waitrequest is high is illegal; behaviour need only be safe (no hang, no spurious readdatavalid beyond the accepted transaction).

Reset
REQ-021 On reset: state IDLE, latched address 0, data register 0, owner m0, last-grant m1, all readdatavalid 0.
REQ-022 Reset mid-transaction SHALL abort it; no readdatavalid pulse for the aborted read.
REQ-023 Waitrequest SHALL be combinational and therefore 1 for any asserted read during the reset cycle.

Configuration
REQ-024 Macro NIOS2_WRIN_ARB_RR_EN defined: simultaneous requests SHALL be granted to the requester not granted most recently (round-robin).
REQ-025 Macro undefined: simultaneous requests SHALL always be granted to m0 (fixed priority); last-grant register omitted.
REQ-026 Single-requester behaviour SHALL be identical in both builds.

Structure
REQ-027 Package nios2_wrin_arb_pkg SHALL hold the FSM state enum, the read-latency constant (3), and the address width (2).
REQ-028 Grant selection SHALL be a sub-module nios2_wrin_arb_pick (requests, last-grant in; one-hot grant out).

Verification
REQ-029 Single read: m0_read, addr 0, PIO readdata 0x2 -> accept cycle 0, m0_readdatavalid cycle 3, m0_readdata 0x00000002.
REQ-030 Simultaneous m0/m1 held high, RR_EN defined -> grants m0, m1, m0, m1; valids at cycles 3, 6, 9, 12.
REQ-031 Same stimulus, RR_EN undefined -> m0 granted every time; m1_waitrequest stays 1 throughout.
REQ-032 m1 read addr 3 accepted, reset asserted in DATA -> no m1_readdatavalid; outputs at reset values next cycle; state IDLE.
REQ-033 m0 read in progress, m1_read asserted in ADDR -> m1_waitrequest 1 in ADDR and DATA, m1 accepted in the cycle of m0_readdatavalid.
REQ-034 s_address check: after an m1 read of addr 2 -> s_address holds 2 while idle until the next accept.

Source files
------------

// File: rtl/nios2_wrin_arb_pkg.sv
// Shared types and constants for the two-requester input-PIO read arbiter.
package nios2_wrin_arb_pkg;

    localparam int ADDR_W       = 2;
    localparam int DATA_W       = 32;
    localparam int READ_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/nios2_wrin_arb_pick.sv
// One-hot grant selection between m0 and m1; round-robin when NIOS2_WRIN_ARB_RR_EN
// is defined, otherwise fixed priority to m0.
module nios2_wrin_arb_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifndef NIOS2_WRIN_ARB_RR_EN
    // Fixed priority never looks at history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
`ifdef NIOS2_WRIN_ARB_RR_EN
            grant = last_grant ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/nios2_wrin_arb.sv
// Shares one input-PIO read port between requesters m0 and m1, one read every 3 cycles.
// Optional round-robin arbitration: define NIOS2_WRIN_ARB_RR_EN.
module nios2_wrin_arb
    import nios2_wrin_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic [ADDR_W-1:0] m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_readdata
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              owner_q;
    logic              last_q;
    logic [1:0]        valid_q;
    logic [1:0]        grant;
    logic [1:0]        accept;

    nios2_wrin_arb_pick u_pick (
        .req        ({m1_read, m0_read}),
        .last_grant (last_q),
        .grant      (grant)
    );

    // Accepting is gated by reset so a read presented during reset is stalled.
    assign accept = (state == ST_IDLE && !reset) ? grant : 2'b00;

    assign m0_waitrequest   = m0_read & ~accept[0];
    assign m1_waitrequest   = m1_read & ~accept[1];
    assign m0_readdata      = data_q;
    assign m1_readdata      = data_q;
    assign m0_readdatavalid = valid_q[0];
    assign m1_readdatavalid = valid_q[1];
    assign s_address        = addr_q;

`ifdef NIOS2_WRIN_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)
            last_q <= 1'b1;
        else if (|accept)
            last_q <= accept[1];
    end
`else
    assign last_q = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            owner_q <= 1'b0;
            valid_q <= 2'b00;
        end else begin
            valid_q <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|accept) begin
                        owner_q <= accept[1];
                        addr_q  <= accept[1] ? m1_address : m0_address;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: state <= ST_DATA;
                ST_DATA: begin
                    // The PIO presents data one clock after s_address, i.e. now.
                    data_q  <= s_readdata;
                    valid_q <= owner_q ? 2'b10 : 2'b01;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_wrin_arb.sv
// Scoreboard bench for nios2_wrin_arb: transaction-level model of the shared PIO port.
module tb_nios2_wrin_arb;
    import nios2_wrin_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m0_read = 1'b0, m1_read = 1'b0;
    logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic [DATA_W-1:0] s_readdata = '0;

    nios2_wrin_arb dut (
        .clk              (clk),
        .reset            (reset),
        .m0_read          (m0_read),
        .m0_address       (m0_address),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_address       (m1_address),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_readdata       (s_readdata)
    );

    always #5 clk = ~clk;

    // Input-PIO slave: registered read one clock after the address.
    logic [DATA_W-1:0] pio_mem [4];
    always @(posedge clk) s_readdata <= pio_mem[s_address];

    typedef struct {
        bit                owner;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0, failures = 0;
    int                cyc = 0;
    int                next_free = 0;
    bit                done = 1'b0;
    bit [1:0]          pend = 2'b00;
    logic [ADDR_W-1:0] paddr [2];
    logic [ADDR_W-1:0] exp_saddr = '0;
    bit                last_m = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One bench cycle: start new requests (held until accepted), apply, predict, check.
    task automatic step(input bit rst, input bit w0, input logic [1:0] a0,
                        input bit w1, input logic [1:0] a1);
        bit acc_v;
        bit acc_id;
        exp_t e;
        @(negedge clk);
        cyc++;
        if (w0 && !pend[0]) begin pend[0] = 1'b1; paddr[0] = a0; end
        if (w1 && !pend[1]) begin pend[1] = 1'b1; paddr[1] = a1; end
        reset      = rst;
        m0_read    = pend[0];
        m0_address = paddr[0];
        m1_read    = pend[1];
        m1_address = paddr[1];
        #1;
        acc_v  = !rst && (cyc >= next_free) && (pend != 2'b00);
        acc_id = 1'b0;
        if (pend == 2'b11) begin
`ifdef NIOS2_WRIN_ARB_RR_EN
            acc_id = ~last_m;
`else
            acc_id = 1'b0;
`endif
        end else begin
            acc_id = pend[1];
        end
        check("m0_waitrequest", 32'(m0_waitrequest), 32'(pend[0] && !(acc_v && acc_id == 1'b0)));
        check("m1_waitrequest", 32'(m1_waitrequest), 32'(pend[1] && !(acc_v && acc_id == 1'b1)));
        check("s_address", 32'(s_address), 32'(exp_saddr));
        if (rst) begin
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
            next_free = cyc + 1;
            exp_saddr = '0;
            last_m    = 1'b1;
        end else if (acc_v) begin
            e.owner = acc_id;
            e.data  = pio_mem[paddr[acc_id]];
            e.due   = cyc + READ_LATENCY;
            sb.push_back(e);
            next_free    = cyc + READ_LATENCY;
            exp_saddr    = paddr[acc_id];
            last_m       = acc_id;
            pend[acc_id] = 1'b0;
        end
    endtask

    // Monitor: every cycle the head of the scoreboard due now must appear, nothing else.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(e.owner == 1'b0));
                check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(e.owner == 1'b1));
                check("m0_readdata", m0_readdata, e.data);
                check("m1_readdata", m1_readdata, e.data);
            end else begin
                check("spurious_valid", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        paddr[0] = '0;
        paddr[1] = '0;
        for (int i = 0; i < 4; i++) pio_mem[i] = $urandom;
        pio_mem[0] = 32'h0000_0002;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Single m0 read of address 0.
        step(0, 1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        // m1 read of address 2; s_address must hold 2 while idle.
        step(0, 0, 0, 1, 2);
        repeat (8) step(0, 0, 0, 0, 0);
        // Both held high: alternation or m0-only depending on build.
        repeat (12) step(0, 1, 1, 1, 3);
        repeat (8) step(0, 0, 0, 0, 0);
        // m1 arrives while m0 is in ADDR.
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 1);
        repeat (8) step(0, 0, 0, 0, 0);
        // m1 read of address 3 aborted by reset in DATA.
        step(0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)));
        end
        repeat (12) step(0, 0, 0, 0, 0);
        done = 1'b1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
